pueo_trig_sched: RTL

Single-clock trigger scheduler for the memclk domain. It replaces the clock-crossing address FIFO in front of the URAM readout. It accepts trigger times, applies a programmable lookback offset, tags each trigger with an event number, and queues up to DEPTH requests. It issues the requests to the URAM reader while limiting the number of readouts in flight, and it counts triggers dropped on overflow.

---
 rtl/pueo_trig_pkg.sv | 17 +
 rtl/pueo_trig_fifo.sv | 52 +++++
 rtl/pueo_trig_sched.sv | 80 ++++++++
 3 files changed

// File: rtl/pueo_trig_pkg.sv
// Shared types and helpers for the memclk trigger scheduler.
package pueo_trig_pkg;

  localparam int TIME_BITS_DEF  = 15;
  localparam int EVNUM_BITS_DEF = 16;
  localparam int OVF_BITS       = 16;

  typedef struct packed {
    logic [EVNUM_BITS_DEF-1:0] evnum;
    logic [TIME_BITS_DEF-1:0]  start;
  } trig_entry_t;

  function automatic logic [OVF_BITS-1:0] sat_inc(input logic [OVF_BITS-1:0] v);
    return (v == {OVF_BITS{1'b1}}) ? v : v + OVF_BITS'(1);
  endfunction

endpackage

// File: rtl/pueo_trig_fifo.sv
// Synchronous first-word-fall-through queue on distributed RAM.
// Latency: a push is visible on head_dat and count after one edge.
// Backpressure: pushes when full and pops when empty are ignored.
module pueo_trig_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && (count != FULL);
  assign pop_ok   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage has no reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pueo_trig_sched.sv
// Trigger scheduler: lookback subtract, event tagging, queueing, in-flight limited issue.
// Latency: a trigger accepted at edge N raises m_tvalid in cycle N+1 when the queue was empty.
// Backpressure: holds the head while m_tready is low; drops and counts triggers when full.
module pueo_trig_sched
  import pueo_trig_pkg::*;
#(
  parameter int TIME_BITS  = 15,
  parameter int EVNUM_BITS = 16,
  parameter int DEPTH      = 8,
  parameter int MAX_OUT    = 1
) (
  input  logic                           memclk_i,
  input  logic                           memclk_rst_i,
  input  logic                           run_i,
  input  logic                           flush_i,
  input  logic [TIME_BITS-1:0]           offset_i,
  input  logic [TIME_BITS-1:0]           trig_time_i,
  input  logic                           trig_valid_i,
  output logic [EVNUM_BITS+TIME_BITS-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  input  logic                           done_i,
  output logic [$clog2(DEPTH):0]         occupancy_o,
  output logic [3:0]                     inflight_o,
  output logic [OVF_BITS-1:0]            overflow_cnt_o,
  output logic [EVNUM_BITS-1:0]          evnum_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [3:0]  MAX_OUT_L = 4'(MAX_OUT);

  logic                 accept;
  logic                 full;
  logic                 push;
  logic                 drop;
  logic                 hs;
  logic                 done_ok;
  logic [TIME_BITS-1:0] start;

  assign accept  = trig_valid_i && run_i && !flush_i;
  assign full    = (occupancy_o == FULL);
  assign push    = accept && !full;
  assign drop    = accept && full;
  assign start   = trig_time_i - offset_i;
  assign hs      = m_tvalid && m_tready;
  assign done_ok = done_i && (inflight_o != 4'd0);

  // Built from registered state; flush_i gates it so nothing issues in the cycle the queue is discarded.
  assign m_tvalid = (occupancy_o != '0) && (inflight_o < MAX_OUT_L) && !flush_i;

  pueo_trig_fifo #(
    .WIDTH (EVNUM_BITS + TIME_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (memclk_i),
    .rst      (memclk_rst_i),
    .flush    (flush_i),
    .push     (push),
    .push_dat ({evnum_o, start}),
    .pop      (hs),
    .head_dat (m_tdata),
    .count    (occupancy_o)
  );

  always_ff @(posedge memclk_i) begin
    if (memclk_rst_i) begin
      evnum_o        <= '0;
      overflow_cnt_o <= '0;
      inflight_o     <= '0;
    end else begin
      // Dropped triggers still consume an event number so downstream sees the gap.
      if (accept) evnum_o <= evnum_o + EVNUM_BITS'(1);
      if (drop)   overflow_cnt_o <= sat_inc(overflow_cnt_o);
      if (hs && !done_ok)      inflight_o <= inflight_o + 4'd1;
      else if (!hs && done_ok) inflight_o <= inflight_o - 4'd1;
    end
  end

endmodule
